// File: rtl/data_unpack_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_unpack_pkg : shared types and constants for the data_unpack arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
package data_unpack_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int ERR_PROTO   = 0;
  localparam int ERR_TIMEOUT = 1;

endpackage
`default_nettype wire

// File: rtl/data_unpack_arb_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, search starts at last_i+1
// Revision 1.0
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic                     found_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int GW = $clog2(N_REQ);

  logic [GW-1:0] w_cand;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    w_cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = GW'((int'(last_i) + k) % N_REQ);
      if (req_i[w_cand]) begin
        found_o = 1'b1;
        idx_o   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_unpack_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_unpack_arb : packet-locked round-robin arbiter in front of data_unpack
// Revision 1.0
// ----------------------------------------------------------------------------
module data_unpack_arb
  import data_unpack_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid_in,
  input  logic [N_REQ-1:0][DATA_W-1:0]     req_data_in,
  input  logic [N_REQ-1:0]                 req_sop_in,
  input  logic [N_REQ-1:0]                 req_eop_in,
  output logic [N_REQ-1:0]                 req_ready_out,
  output logic                             unp_valid_out,
  output logic [DATA_W-1:0]                unp_data_out,
  output logic                             unp_sop_out,
  output logic                             unp_eop_out,
  input  logic                             unp_ready_in,
  output logic [$clog2(N_REQ)-1:0]         grant_out,
  output logic                             locked_out,
  output logic [1:0]                       err_out
);

  localparam int GW   = $clog2(N_REQ);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  arb_state_t          state_q;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       last_grant_q;
  logic                first_q;
  logic [WD_W-1:0]     wd_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_sop_q;
  logic                out_eop_q;
  logic [1:0]          err_q;

  logic                w_found;
  logic [GW-1:0]       w_winner;
  logic                w_slot_free;
  logic                w_owner_valid;
  logic                w_accept;
  logic                w_wd_expire;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i   (req_valid_in),
    .last_i  (last_grant_q),
    .found_o (w_found),
    .idx_o   (w_winner)
  );

  assign w_slot_free   = !out_valid_q || unp_ready_in;
  assign w_owner_valid = req_valid_in[grant_q];
  assign w_accept      = (state_q == LOCKED) && w_owner_valid && w_slot_free;
  // Expiry needs an idle owner, so an accepted beat always takes precedence.
  assign w_wd_expire   = (TIMEOUT > 0) && (state_q == LOCKED) && !w_owner_valid
                         && (wd_q == WD_LAST);

  always_comb begin
    req_ready_out = '0;
    if (state_q == LOCKED) req_ready_out[grant_q] = w_slot_free;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      first_q      <= 1'b0;
      wd_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      err_q        <= '0;
    end else begin
      if (w_accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= req_data_in[grant_q];
        out_sop_q   <= req_sop_in[grant_q];
        out_eop_q   <= req_eop_in[grant_q];
      end else if (unp_ready_in) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (w_found) begin
            grant_q <= w_winner;
            first_q <= 1'b1;
            wd_q    <= '0;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_accept) begin
            wd_q    <= '0;
            first_q <= 1'b0;
            if (req_sop_in[grant_q] && !first_q) err_q[ERR_PROTO] <= 1'b1;
            if (req_eop_in[grant_q]) begin
              state_q      <= IDLE;
              last_grant_q <= grant_q;
            end
          end else if (w_wd_expire) begin
            err_q[ERR_TIMEOUT] <= 1'b1;
            wd_q               <= '0;
            state_q            <= IDLE;
            last_grant_q       <= grant_q;
          end else if ((TIMEOUT > 0) && !w_owner_valid) begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign unp_valid_out = out_valid_q;
  assign unp_data_out  = out_data_q;
  assign unp_sop_out   = out_sop_q;
  assign unp_eop_out   = out_eop_q;
  assign grant_out     = grant_q;
  assign locked_out    = (state_q == LOCKED);
  assign err_out       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_unpack_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_data_unpack_arb : randomized scoreboard bench for data_unpack_arb
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_data_unpack_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          first;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } obeat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid_in;
  logic [N-1:0][DW-1:0] req_data_in;
  logic [N-1:0]         req_sop_in;
  logic [N-1:0]         req_eop_in;
  logic [N-1:0]         req_ready_out;
  logic                 unp_valid_out;
  logic [DW-1:0]        unp_data_out;
  logic                 unp_sop_out;
  logic                 unp_eop_out;
  logic                 unp_ready_in;
  logic [1:0]           grant_out;
  logic                 locked_out;
  logic [1:0]           err_out;

  always #5 clk = ~clk;

  data_unpack_arb #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_in  (req_valid_in),
    .req_data_in   (req_data_in),
    .req_sop_in    (req_sop_in),
    .req_eop_in    (req_eop_in),
    .req_ready_out (req_ready_out),
    .unp_valid_out (unp_valid_out),
    .unp_data_out  (unp_data_out),
    .unp_sop_out   (unp_sop_out),
    .unp_eop_out   (unp_eop_out),
    .unp_ready_in  (unp_ready_in),
    .grant_out     (grant_out),
    .locked_out    (locked_out),
    .err_out       (err_out)
  );

  beat_t  stage_q[N][$];
  beat_t  src_q[N][$];
  obeat_t exp_q[$];
  int     model_last;
  int     acc_cnt[N];
  bit     gaps_en;
  bit     bp_en;
  int     n_checks;
  int     n_fails;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stage_beat(int r, logic [DW-1:0] d, logic s, logic e, logic f);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.first = f;
    stage_q[r].push_back(b);
  endtask

  task automatic stage_pkt(int r, int len);
    for (int i = 0; i < len; i++) stage_beat(r, $urandom, i == 0, i == len - 1, i == 0);
  endtask

  // Packet-level reference: whole packets leave in round-robin order over
  // requesters that still have packets, starting after the last owner.
  task automatic launch(output int first_w);
    int r; bit any; beat_t b; obeat_t o;
    first_w = -1;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      r = 0;
      for (int k = 1; k <= N; k++) begin
        if (!any && stage_q[(model_last + k) % N].size() > 0) begin
          any = 1'b1;
          r = (model_last + k) % N;
        end
      end
      if (any) begin
        if (first_w < 0) first_w = r;
        do begin
          b = stage_q[r].pop_front();
          src_q[r].push_back(b);
          o.data = b.data; o.sop = b.sop; o.eop = b.eop;
          exp_q.push_back(o);
        end while (stage_q[r].size() > 0 && !stage_q[r][0].first);
        model_last = r;
      end
    end
  endtask

  task automatic drv_loop();
    logic [N-1:0] hs;
    int gap[N];
    beat_t b;
    for (int i = 0; i < N; i++) gap[i] = 0;
    forever begin
      @(negedge clk);
      hs = req_valid_in & req_ready_out;
      @(posedge clk);
      #1;
      if (!rst) begin
        for (int r = 0; r < N; r++) begin
          src_q[r].delete();
          gap[r] = 0;
        end
        req_valid_in = '0; req_sop_in = '0; req_eop_in = '0;
        unp_ready_in = 1'b1;
      end else begin
        for (int r = 0; r < N; r++) begin
          if (hs[r]) begin
            b = src_q[r].pop_front();
            acc_cnt[r]++;
          end
          if (!req_valid_in[r] || hs[r]) begin
            if (src_q[r].size() == 0) begin
              req_valid_in[r] = 1'b0;
            end else if (src_q[r][0].first || !gaps_en || gap[r] >= 2 ||
                         $urandom_range(3) != 0) begin
              req_valid_in[r] = 1'b1;
              req_data_in[r]  = src_q[r][0].data;
              req_sop_in[r]   = src_q[r][0].sop;
              req_eop_in[r]   = src_q[r][0].eop;
              gap[r] = 0;
            end else begin
              req_valid_in[r] = 1'b0;
              gap[r]++;
            end
          end
        end
        unp_ready_in = bp_en ? 1'($urandom_range(1)) : 1'b1;
      end
    end
  endtask

  task automatic mon_loop();
    obeat_t e;
    logic pend;
    logic [DW+1:0] pbeat;
    pend = 1'b0;
    pbeat = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("latency_valid", unp_valid_out, 1);
        check("latency_beat", {unp_data_out, unp_sop_out, unp_eop_out}, pbeat);
      end
      pend = 1'b0;
      if (rst) begin
        for (int r = 0; r < N; r++) begin
          if (req_valid_in[r] && req_ready_out[r]) begin
            pend  = 1'b1;
            pbeat = {req_data_in[r], req_sop_in[r], req_eop_in[r]};
          end
        end
      end
      check("ready_onehot", $countones(req_ready_out) <= 1, 1);
      if (unp_valid_out && !unp_ready_in) check("ready_when_full", req_ready_out, 0);
      if (unp_valid_out && unp_ready_in) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", unp_data_out);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", {unp_data_out, unp_sop_out, unp_eop_out}, e);
        end
      end
    end
  endtask

  task automatic check_reset(string tag);
    check({tag, "_ready"},  req_ready_out, 0);
    check({tag, "_valid"},  unp_valid_out, 0);
    check({tag, "_data"},   unp_data_out,  0);
    check({tag, "_sop"},    unp_sop_out,   0);
    check({tag, "_eop"},    unp_eop_out,   0);
    check({tag, "_grant"},  grant_out,     0);
    check({tag, "_locked"}, locked_out,    0);
    check({tag, "_err"},    err_out,       0);
  endtask

  task automatic check_first_grant(string name, int exp_w);
    int cyc = 0;
    while (!locked_out && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!locked_out) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: got no lock, expected grant %0d", name, exp_w);
    end else begin
      check(name, grant_out, exp_w);
    end
  endtask

  task automatic drain(string name, int budget);
    int cyc = 0;
    bit done = 1'b0;
    bit empty;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      empty = 1'b1;
      for (int r = 0; r < N; r++) if (src_q[r].size() != 0) empty = 1'b0;
      done = empty && exp_q.size() == 0 && req_valid_in == '0 && !locked_out && !unp_valid_out;
    end
    check(name, done, 1);
    if (!done) exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int w, c0, cyc;
    beat_t b;
    obeat_t o;
    rst = 1'b0;
    req_valid_in = '0; req_data_in = '0; req_sop_in = '0; req_eop_in = '0;
    unp_ready_in = 1'b1;
    gaps_en = 1'b0; bp_en = 1'b0;
    n_checks = 0; n_fails = 0;
    model_last = N - 1;
    for (int r = 0; r < N; r++) acc_cnt[r] = 0;
    fork
      drv_loop();
      mon_loop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("init");
    rst = 1'b1;

    // single source, three beats
    stage_beat(0, 32'h11111111, 1'b1, 1'b0, 1'b1);
    stage_beat(0, 32'h22222222, 1'b0, 1'b0, 1'b0);
    stage_beat(0, 32'h33333333, 1'b0, 1'b1, 1'b0);
    launch(w);
    check_first_grant("single_grant", 0);
    drain("single_drain", 100);

    // fairness: everyone has back-to-back two-beat packets
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < N; r++) stage_pkt(r, 2);
    launch(w);
    check_first_grant("fair_first_grant", w);
    drain("fair_drain", 300);
    check("fair_err", err_out, 0);

    // backpressure on one long packet, then a random mix
    bp_en = 1'b1;
    stage_pkt(2, 5);
    launch(w);
    check_first_grant("bp_grant", 2);
    drain("bp_drain", 200);
    gaps_en = 1'b1;
    for (int p = 0; p < 24; p++) stage_pkt(int'($urandom_range(N - 1)), int'($urandom_range(5, 1)));
    launch(w);
    drain("rand_drain", 3000);
    bp_en = 1'b0; gaps_en = 1'b0;
    check("rand_err", err_out, 0);

    // SOP inside a packet
    stage_beat(1, $urandom, 1'b1, 1'b0, 1'b1);
    stage_beat(1, $urandom, 1'b0, 1'b0, 1'b0);
    stage_beat(1, $urandom, 1'b1, 1'b0, 1'b0);
    stage_beat(1, $urandom, 1'b0, 1'b1, 1'b0);
    stage_pkt(3, 2);
    launch(w);
    drain("proto_drain", 200);
    check("proto_err", err_out, 2'b01);

    // watchdog: one beat with no EOP, then silence
    stage_beat(3, $urandom, 1'b1, 1'b0, 1'b1);
    launch(w);
    c0 = acc_cnt[3];
    cyc = 0;
    while (acc_cnt[3] == c0 && cyc < 50) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("wd_beat_taken", acc_cnt[3] != c0, 1);
    repeat (8) @(negedge clk);
    check("wd_locked_before", locked_out, 1);
    check("wd_err_before", err_out, 2'b01);
    @(negedge clk);
    check("wd_locked_after", locked_out, 0);
    check("wd_err_after", err_out, 2'b11);
    stage_pkt(2, 2);
    stage_pkt(0, 2);
    launch(w);
    check_first_grant("wd_next_grant", 0);
    drain("wd_drain", 200);

    // reset during beat 2 of a packet; only beat 1 ever reaches the output
    for (int i = 0; i < 4; i++) begin
      b.data = $urandom; b.sop = (i == 0); b.eop = (i == 3); b.first = (i == 0);
      src_q[2].push_back(b);
      if (i == 0) begin
        o.data = b.data; o.sop = b.sop; o.eop = b.eop;
        exp_q.push_back(o);
      end
    end
    c0 = acc_cnt[2];
    cyc = 0;
    while (acc_cnt[2] == c0 && cyc < 50) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("rstmid_beat_taken", acc_cnt[2] != c0, 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("rstmid");
    rst = 1'b1;
    check("rstmid_flushed", exp_q.size(), 0);
    exp_q.delete();
    model_last = N - 1;
    stage_pkt(1, 2);
    stage_pkt(0, 3);
    launch(w);
    check_first_grant("rstmid_grant", 0);
    drain("rstmid_drain", 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_unpack_arb.md
# data_unpack_arb

Packet-level round-robin arbiter that shares one `data_unpack` instance between `N_REQ` upstream 32-bit packet sources. Once a requester wins, its grant is locked from the first beat until its EOP beat is accepted, so packets are never interleaved inside the unpacker. The output side connects directly to `data_unpack` (`valid_in`, `data_in`, `sop_in`, `eop_in`, `ready_out`) through one registered stage. A watchdog breaks locks held by stalled sources.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `DATA_W`, default 32: beat width; must match the `data_unpack` input.
- `TIMEOUT`, default 64: idle cycles tolerated inside a locked packet; 0 disables the watchdog.
- `clk`  in  1: system clock; all logic is rising-edge.
- `rst`  in  1: reset, synchronous, active-low.
- `req_valid_in`  in  N_REQ: per-requester beat valid.
- `req_data_in`  in  N_REQ×DATA_W: per-requester beat data.
- `req_sop_in`  in  N_REQ: per-requester start-of-packet flag.
- `req_eop_in`  in  N_REQ: per-requester end-of-packet flag.
- `req_ready_out`  out  N_REQ: per-requester accept; at most one bit is high.
- `unp_valid_out`  out  1: beat valid toward `data_unpack`.
- `unp_data_out`  out  DATA_W: beat data.
- `unp_sop_out`  out  1: start-of-packet flag.
- `unp_eop_out`  out  1: end-of-packet flag.
- `unp_ready_in`  in  1: `data_unpack` ready.
- `grant_out`  out  $clog2(N_REQ): index of the current or last owner.
- `locked_out`  out  1: a packet is in progress.
- `err_out`  out  2: sticky flags. Bit 0 = protocol error (SOP inside a packet). Bit 1 = watchdog timeout.

## Operation
- A beat transfers on a rising edge where valid and ready are both high, on either side.
- States:
  - **IDLE**: no owner.
    - If any `req_valid_in` is high, pick a winner round-robin, starting at (`last_grant`+1) mod `N_REQ` and wrapping.
    - Register the winner in `grant_out` and go to LOCKED.
    - No beat is accepted in the arbitration cycle.
  - **LOCKED**:
    - `req_ready_out[grant]` = (!`unp_valid_out` || `unp_ready_in`); all other bits are 0.
    - An accepted beat loads the output register.
    - An accepted beat with `eop`=1 sets `last_grant`=`grant` and goes to IDLE on the same edge.
- The first beat after a grant is forwarded with its own `sop` flag, unmodified. A missing SOP is not an error.
- A beat accepted with `sop`=1 that is not the first beat of the lock sets `err_out[0]`. That beat is still forwarded.
- A single-beat packet (`sop`=`eop`=1) is legal: lock, one beat, release.
- Watchdog (`TIMEOUT`>0):
  - A counter increments each LOCKED cycle where `req_valid_in[grant]`=0.
  - It clears on every accepted beat.
  - When it reaches `TIMEOUT`: set `err_out[1]`, go to IDLE, set `last_grant`=`grant`.
  - No EOP is synthesised. The unpacker sees a truncated packet.
- Output register: it holds its beat until `unp_ready_in`. New data loads only when the register is empty or draining, giving full throughput.
- `err_out` clears only on reset.

## Timing
- Reset values: `req_ready_out`=0, `unp_valid_out`=0, `unp_data_out`=0, `unp_sop_out`=0, `unp_eop_out`=0, `grant_out`=0, `locked_out`=0, `err_out`=0.
- Reset state: IDLE, `last_grant`=N_REQ-1, so requester 0 has first priority.
- Latency: a beat accepted at edge k is presented on `unp_*_out` from edge k onward. Latency is 1 cycle.
- Packet overhead: 1 arbitration cycle between packets. Back-to-back packets run at N/(N+1) beat efficiency.
- `req_ready_out` is combinational from state and `unp_ready_in`. There is no combinational path from `req_valid_in` to `unp_*_out`.
- Simultaneous EOP acceptance and a new request: the new request is arbitrated in the following IDLE cycle. The releasing requester has lowest priority.
- Reset asserted mid-packet: on that edge, drop the output register, drop the lock, and return to the reset values.
- Watchdog expiry on the same edge as a beat acceptance: the acceptance wins and the counter clears.
- `unp_ready_in` low while the register is full: all `req_ready_out`=0. `unp_*_out` stay stable until the transfer.

## Structure
- Package `data_unpack_pkg`:
  - `DATA_W` default constant.
  - `arb_state_t` enum {IDLE, LOCKED}.
  - Error bit index constants `ERR_PROTO`=0, `ERR_TIMEOUT`=1.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs: request vector, `last_grant`. Outputs: `found`, winner index. It is parameterised by `N_REQ`.
- Top level holds:
  - state register;
  - grant and `last_grant` registers;
  - first-beat flag;
  - watchdog counter of width $clog2(TIMEOUT+1);
  - output register.

## Test plan
- **Single source.** Requester 0 sends a 3-beat packet, data 0x11111111/0x22222222/0x33333333, sop on beat 1, eop on beat 3, with `unp_ready_in`=1.
  - Expect: `grant_out`=0, output beats one cycle after each accept, `unp_sop_out`/`unp_eop_out` on beats 1/3, then return to IDLE.
- **Fairness.** All 4 requesters continuously present 2-beat packets.
  - Expect: grant order 0,1,2,3,0…, no interleaving within a packet, `err_out`=0.
- **Backpressure.** `unp_ready_in` toggles randomly during a 5-beat packet from requester 2.
  - Expect: no beat lost or duplicated, data order preserved, `req_ready_out` low whenever the register is full and `unp_ready_in`=0.
- **Protocol error.** Requester 1 sends sop on beats 1 and 3 of a 4-beat packet.
  - Expect: all 4 beats forwarded, `err_out[0]`=1 after beat 3, lock held until eop.
- **Watchdog.** With `TIMEOUT`=8, requester 3 sends 1 beat (sop, no eop), then drops valid.
  - Expect: `err_out[1]`=1 and `locked_out`=0 after 8 idle cycles, then requester 0 is granted next.
- **Reset mid-packet.** Drive `rst`=0 for 1 cycle during beat 2 of a packet.
  - Expect: all outputs at reset values on the next edge. After release, requester 0 has first priority.
